hw_regs_dbuf: RTL and testbench

Next-generation hardware control register bank on the cache-line write bus. It is a parametrised byte array with several new features:
- double-buffered staging/live copies, committed immediately or on a VSYNC/commit request;
- registered read-back port;
- sequential default-value loader after reset;
- wrap-safe 16/32-bit views.

The live copy drives display/peripheral control logic. The staging copy is what the host writes and reads.

---
 rtl/hw_regs_dbuf.sv | 141 ++++++++++++++
 tb/tb_hw_regs_dbuf.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_regs_dbuf.sv
// hw_regs_dbuf: double-buffered byte register bank with default loader, read-back port and wrap-safe 16/32-bit live views
module hw_regs_dbuf #(
    parameter ENDIAN = "Big",
    parameter int PORT_ADDR_SIZE = 19,
    parameter int PORT_CACHE_BITS = 128,
    parameter int HW_REGS_SIZE = 8,
    parameter logic [31:0] BASE_WRITE_ADDRESS = 32'h0,
    parameter int COMMIT_MODE = 0,
    parameter int RST_PARAM_SIZE = 4,
    parameter logic [23:0] RESET_VALUES [0:(RST_PARAM_SIZE > 0 ? RST_PARAM_SIZE : 1)-1] =
        '{{16'h00, 8'h10}, {16'h01, 8'h00}, {16'h02, 8'h10}, {16'h03, 8'h00}}
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic                                WE,
    input  logic                                RE,
    input  logic [PORT_ADDR_SIZE-1:0]           ADDR_IN,
    input  logic [PORT_CACHE_BITS-1:0]          DATA_IN,
    input  logic [PORT_CACHE_BITS/8-1:0]        WMASK,
    input  logic                                VSYNC_IN,
    input  logic                                COMMIT_REQ,
    output logic [PORT_CACHE_BITS-1:0]          RD_DATA,
    output logic                                RD_VALID,
    output logic                                BUSY,
    output logic                                COMMIT_PEND,
    output logic [8*(1<<HW_REGS_SIZE)-1:0]      HW_REGS__8bit,
    output logic [16*(1<<HW_REGS_SIZE)-1:0]     HW_REGS_16bit,
    output logic [32*(1<<HW_REGS_SIZE)-1:0]     HW_REGS_32bit
);
    localparam int N  = PORT_CACHE_BITS / 8;
    localparam int LN = $clog2(N);
    localparam int R  = 1 << HW_REGS_SIZE;
    localparam int RA = RST_PARAM_SIZE > 0 ? RST_PARAM_SIZE : 1;
    localparam int IW = RA > 1 ? $clog2(RA) : 1;
    localparam logic [255:0] ENDIAN_V = 256'(ENDIAN);

    // The highest non-zero byte of the packed literal is its first character.
    function automatic logic is_big(input logic [255:0] s);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 32; i++)
            if (s[i*8+:8] != 8'h00) r = (s[i*8+:8] == "B");
        return r;
    endfunction

    localparam logic BIG = is_big(ENDIAN_V);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t                         r_state, w_next;
    logic [IW-1:0]                  r_idx;
    logic [7:0]                     r_stage [R];
    logic [7:0]                     r_live [R];
    logic                           r_vsync_d;
    logic                           r_pend;
    logic                           r_rd_valid;
    logic [PORT_CACHE_BITS-1:0]     r_rd_data;
    logic                           w_en, w_wr, w_rd, w_commit, w_init_wr;
    logic [HW_REGS_SIZE-LN-1:0]     w_line;
    logic [HW_REGS_SIZE-1:0]        w_ld_addr;
    logic [7:0]                     w_ld_val;
    logic                           w_unused;

    assign w_en      = ADDR_IN[PORT_ADDR_SIZE-1:HW_REGS_SIZE] == BASE_WRITE_ADDRESS[PORT_ADDR_SIZE-1:HW_REGS_SIZE];
    assign w_wr      = WE & w_en & (r_state == ST_IDLE);
    assign w_rd      = RE & w_en & (r_state == ST_IDLE);
    assign w_commit  = (COMMIT_MODE != 0) && (r_state == ST_IDLE) && ((VSYNC_IN & ~r_vsync_d) | COMMIT_REQ);
    assign w_line    = ADDR_IN[HW_REGS_SIZE-1:LN];
    assign w_ld_addr = RESET_VALUES[r_idx][8 +: HW_REGS_SIZE];
    assign w_ld_val  = RESET_VALUES[r_idx][7:0];
    assign w_init_wr = (r_state == ST_INIT) && (RST_PARAM_SIZE > 0);
    assign w_unused  = ^ADDR_IN[LN-1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            r_idx   <= (r_state == ST_INIT) ? r_idx + 1'b1 : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_INIT && (RST_PARAM_SIZE == 0 || r_idx == IW'(RA - 1)))
            w_next = ST_IDLE;
    end

    // Commit copies the pre-edge staging, so a same-cycle write stays pending.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < R; k++) begin
                r_stage[k] <= 8'h00;
                r_live[k]  <= 8'h00;
            end
        end else if (w_init_wr) begin
            r_stage[w_ld_addr] <= w_ld_val;
            r_live[w_ld_addr]  <= w_ld_val;
        end else begin
            if (w_commit)
                for (int k = 0; k < R; k++) r_live[k] <= r_stage[k];
            if (w_wr)
                for (int i = 0; i < N; i++)
                    if (WMASK[i]) begin
                        r_stage[{w_line, LN'(N-1-i)}] <= DATA_IN[i*8+:8];
                        if (COMMIT_MODE == 0) r_live[{w_line, LN'(N-1-i)}] <= DATA_IN[i*8+:8];
                    end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_vsync_d  <= 1'b1;
            r_pend     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_vsync_d  <= VSYNC_IN;
            r_pend     <= (COMMIT_MODE == 0) ? 1'b0 : w_wr ? 1'b1 : w_commit ? 1'b0 : r_pend;
            r_rd_valid <= w_rd;
            if (w_rd)
                for (int i = 0; i < N; i++) r_rd_data[i*8+:8] <= r_stage[{w_line, LN'(N-1-i)}];
        end
    end

    assign BUSY        = r_state == ST_INIT;
    assign COMMIT_PEND = r_pend;
    assign RD_VALID    = r_rd_valid;
    assign RD_DATA     = r_rd_data;

    for (genvar j = 0; j < R; j++) begin : g_view
        localparam int J1 = (j + 1) % R;
        localparam int J2 = (j + 2) % R;
        localparam int J3 = (j + 3) % R;
        assign HW_REGS__8bit[j*8+:8]   = r_live[j];
        assign HW_REGS_16bit[j*16+:16] = BIG ? {r_live[j], r_live[J1]} : {r_live[J1], r_live[j]};
        assign HW_REGS_32bit[j*32+:32] = BIG ? {r_live[j], r_live[J1], r_live[J2], r_live[J3]}
                                             : {r_live[J3], r_live[J2], r_live[J1], r_live[j]};
    end
endmodule

// File: tb/tb_hw_regs_dbuf.sv
// tb_hw_regs_dbuf: scoreboard bench for a commit-mode big-endian bank and an immediate-mode little-endian bank
module tb_hw_regs_dbuf;
    logic         CLK = 0, RESET = 0, WE = 0, RE = 0, VSYNC_IN = 0, COMMIT_REQ = 0;
    logic [18:0]  ADDR_IN = '0;
    logic [127:0] DATA_IN = '0;
    logic [15:0]  WMASK = '0;
    logic [127:0] a_rdd, b_rdd;
    logic         a_rdv, b_rdv, a_busy, b_busy, a_pend, b_pend;
    logic [2047:0] a_b8, b_b8;
    logic [4095:0] a_16, b_16;
    logic [8191:0] a_32, b_32;
    int n_cmp = 0, n_err = 0;

    typedef struct {string n; int k; int i; logic [127:0] v;} chk_t;
    chk_t         chk_q[$];
    chk_t         c;
    logic [127:0] qa[$], qb[$];

    localparam int K_BUSY = 0, K_PEND = 1, K_RDV = 2, K_B8 = 3, K_16 = 4, K_32 = 5, K_RDD = 6, KB = 8;

    always #5 CLK = ~CLK;

    hw_regs_dbuf #(.COMMIT_MODE(1)) u_a (
        .CLK(CLK), .RESET(RESET), .WE(WE), .RE(RE), .ADDR_IN(ADDR_IN), .DATA_IN(DATA_IN),
        .WMASK(WMASK), .VSYNC_IN(VSYNC_IN), .COMMIT_REQ(COMMIT_REQ), .RD_DATA(a_rdd),
        .RD_VALID(a_rdv), .BUSY(a_busy), .COMMIT_PEND(a_pend), .HW_REGS__8bit(a_b8),
        .HW_REGS_16bit(a_16), .HW_REGS_32bit(a_32));

    hw_regs_dbuf #(.ENDIAN("Little"), .COMMIT_MODE(0)) u_b (
        .CLK(CLK), .RESET(RESET), .WE(WE), .RE(RE), .ADDR_IN(ADDR_IN), .DATA_IN(DATA_IN),
        .WMASK(WMASK), .VSYNC_IN(VSYNC_IN), .COMMIT_REQ(COMMIT_REQ), .RD_DATA(b_rdd),
        .RD_VALID(b_rdv), .BUSY(b_busy), .COMMIT_PEND(b_pend), .HW_REGS__8bit(b_b8),
        .HW_REGS_16bit(b_16), .HW_REGS_32bit(b_32));

    function automatic logic [127:0] sel(int k, int i);
        case (k)
            K_BUSY:      return 128'(a_busy);
            K_PEND:      return 128'(a_pend);
            K_RDV:       return 128'(a_rdv);
            K_B8:        return 128'(a_b8[i*8+:8]);
            K_16:        return 128'(a_16[i*16+:16]);
            K_32:        return 128'(a_32[i*32+:32]);
            K_RDD:       return a_rdd;
            KB + K_BUSY: return 128'(b_busy);
            KB + K_PEND: return 128'(b_pend);
            KB + K_RDV:  return 128'(b_rdv);
            KB + K_B8:   return 128'(b_b8[i*8+:8]);
            KB + K_16:   return 128'(b_16[i*16+:16]);
            KB + K_32:   return 128'(b_32[i*32+:32]);
            KB + K_RDD:  return b_rdd;
            default:     return 'x;
        endcase
    endfunction

    task automatic cmp(input string n, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: read-back lines are popped as RD_VALID appears; state checks are drained each negedge.
    always @(negedge CLK) begin
        if (a_rdv) begin
            if (qa.size() == 0) cmp("a_rd_unexpected", 128'(a_rdv), 128'(0));
            else cmp("a_rd_data", a_rdd, qa.pop_front());
        end
        if (b_rdv) begin
            if (qb.size() == 0) cmp("b_rd_unexpected", 128'(b_rdv), 128'(0));
            else cmp("b_rd_data", b_rdd, qb.pop_front());
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            cmp(c.n, sel(c.k, c.i), c.v);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string n, input int k, input int i, input logic [127:0] v);
        chk_q.push_back('{n, k, i, v});
    endtask

    task automatic put(input int a, input logic [7:0] v);
        ADDR_IN = 19'(a & ~15);
        WMASK   = 16'(1) << (15 - (a % 16));
        DATA_IN = 128'(v) << (8 * (15 - (a % 16)));
        WE      = 1;
    endtask

    task automatic idle_in();
        WE = 0;
        RE = 0;
        COMMIT_REQ = 0;
    endtask

    task automatic expect_rd(input logic [127:0] v);
        qa.push_back(v);
        qb.push_back(v);
    endtask

    task automatic init_seq(input string tag);
        chk({tag, "_busy_pre"}, K_BUSY, 0, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("%s_a_busy%0d", tag, k), K_BUSY, 0, 128'(k < 3));
            chk($sformatf("%s_b_busy%0d", tag, k), KB + K_BUSY, 0, 128'(k < 3));
        end
        idle_in();
        chk({tag, "_a_b8_0"}, K_B8, 0, 8'h10);
        chk({tag, "_a_b8_1"}, K_B8, 1, 8'h00);
        chk({tag, "_a_b8_2"}, K_B8, 2, 8'h10);
        chk({tag, "_a_b8_3"}, K_B8, 3, 8'h00);
        chk({tag, "_a_16_0"}, K_16, 0, 16'h1000);
        chk({tag, "_a_32_0"}, K_32, 0, 32'h10001000);
        chk({tag, "_b_16_0"}, KB + K_16, 0, 16'h0010);
        chk({tag, "_b_32_0"}, KB + K_32, 0, 32'h00100010);
        chk({tag, "_a_pend"}, K_PEND, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #1 RESET = 1;
        chk("rst_a_busy", K_BUSY, 0, 1);
        chk("rst_b_busy", KB + K_BUSY, 0, 1);
        chk("rst_a_pend", K_PEND, 0, 0);
        chk("rst_a_rdv", K_RDV, 0, 0);
        chk("rst_a_rdd", K_RDD, 0, 0);
        chk("rst_a_b8_0", K_B8, 0, 0);
        tick();
        tick();
        RESET = 0;
        put(16'h10, 8'hAB);
        init_seq("init");
        chk("busy_wr_ignored", KB + K_B8, 16'h10, 0);

        put(16'h10, 8'hAB);
        tick();
        idle_in();
        chk("m0_b8_10", KB + K_B8, 16'h10, 8'hAB);
        chk("m0_b8_1f", KB + K_B8, 16'h1F, 0);
        chk("m0_pend", KB + K_PEND, 0, 0);
        chk("m1_b8_10_held", K_B8, 16'h10, 0);
        chk("m1_pend_set", K_PEND, 0, 1);

        put(16'h20, 8'h55);
        tick();
        idle_in();
        chk("m1_b8_20_held", K_B8, 16'h20, 0);
        chk("m0_b8_20", KB + K_B8, 16'h20, 8'h55);
        VSYNC_IN = 1;
        tick();
        chk("vs_b8_20", K_B8, 16'h20, 8'h55);
        chk("vs_b8_10", K_B8, 16'h10, 8'hAB);
        chk("vs_pend_clr", K_PEND, 0, 0);
        put(16'h20, 8'h66);
        tick();
        idle_in();
        tick();
        chk("vs_held_no_commit", K_B8, 16'h20, 8'h55);
        chk("vs_held_pend", K_PEND, 0, 1);
        VSYNC_IN = 0;

        put(16'h30, 8'h11);
        tick();
        idle_in();
        COMMIT_REQ = 1;
        tick();
        COMMIT_REQ = 0;
        chk("creq_b8_30", K_B8, 16'h30, 8'h11);
        chk("creq_b8_20", K_B8, 16'h20, 8'h66);
        chk("creq_pend", K_PEND, 0, 0);
        put(16'h30, 8'h77);
        COMMIT_REQ = 1;
        tick();
        idle_in();
        chk("simul_live_old", K_B8, 16'h30, 8'h11);
        chk("simul_pend", K_PEND, 0, 1);
        chk("simul_m0_b8_30", KB + K_B8, 16'h30, 8'h77);
        RE = 1;
        ADDR_IN = 19'h30;
        COMMIT_REQ = 1;
        expect_rd({8'h77, 120'h0});
        tick();
        idle_in();
        chk("creq2_b8_30", K_B8, 16'h30, 8'h77);
        chk("creq2_pend", K_PEND, 0, 0);

        RE = 1;
        ADDR_IN = 19'h0;
        expect_rd({32'h10001000, 96'h0});
        tick();
        RE = 0;
        chk("rd_valid_a", K_RDV, 0, 1);
        chk("rd_valid_b", KB + K_RDV, 0, 1);
        tick();
        chk("rd_valid_drop", K_RDV, 0, 0);
        chk("rd_data_hold", K_RDD, 0, {32'h10001000, 96'h0});

        put(16'h30, 8'h99);
        RE = 1;
        expect_rd({8'h77, 120'h0});
        tick();
        idle_in();
        chk("rw_m0_b8_30", KB + K_B8, 16'h30, 8'h99);

        put(16'h10, 8'hEE);
        ADDR_IN = ADDR_IN | 19'h40000;
        RE = 1;
        tick();
        idle_in();
        chk("oow_a_rdv", K_RDV, 0, 0);
        chk("oow_b_rdv", KB + K_RDV, 0, 0);
        chk("oow_b8_10", KB + K_B8, 16'h10, 8'hAB);

        put(16'hFF, 8'hCD);
        tick();
        idle_in();
        chk("wrap_m0_b8_ff", KB + K_B8, 255, 8'hCD);
        chk("wrap_le_16_255", KB + K_16, 255, 16'h10CD);
        COMMIT_REQ = 1;
        tick();
        COMMIT_REQ = 0;
        chk("wrap_be_16_255", K_16, 255, 16'hCD10);
        chk("wrap_be_32_254", K_32, 254, 32'h00CD1000);

        put(16'h40, 8'h12);
        RE = 1;
        tick();
        idle_in();
        #1 RESET = 1;
        chk("arst_a_busy", K_BUSY, 0, 1);
        chk("arst_b_busy", KB + K_BUSY, 0, 1);
        chk("arst_pend", K_PEND, 0, 0);
        chk("arst_rdv", K_RDV, 0, 0);
        chk("arst_a_b8_20", K_B8, 16'h20, 0);
        chk("arst_b_b8_10", KB + K_B8, 16'h10, 0);
        tick();
        RESET = 0;
        init_seq("reinit");
        chk("reinit_b8_ff", K_B8, 255, 0);
        tick();
        tick();
        cmp("rd_queue_drained", 128'(qa.size() + qb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
